// File: rtl/blend_pkg.sv
// Shared constants and types for the pipelined alpha blender.
// Blend constants are derived from the alpha width by helper functions.
package blend_pkg;

  localparam int DEF_CH_W    = 12;
  localparam int DEF_ALPHA_W = 8;

  typedef logic [DEF_CH_W+DEF_ALPHA_W-1:0] prod_t;

  function automatic int amax(input int aw);
    return (1 << aw) - 1;
  endfunction

  function automatic int rnd(input int aw);
    return (1 << (aw - 1)) - 1;
  endfunction

endpackage

// File: rtl/blend_lane.sv
// One colour channel of the blender: S1 product registers,
// S2 output register with rounding and optional exact pass-through.
module blend_lane
  import blend_pkg::*;
#(
  parameter int CH_W       = 12,
  parameter int ALPHA_W    = 8,
  parameter int EXACT_ENDS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s1_load,
  input  logic               s2_load,
  input  logic [CH_W-1:0]    in1,
  input  logic [CH_W-1:0]    in2,
  input  logic [ALPHA_W-1:0] alpha,
  input  logic               a_zero,
  input  logic               a_max,
  output logic [CH_W-1:0]    outp
);

  localparam int PW = CH_W + ALPHA_W;
  localparam logic [ALPHA_W-1:0] AMAX = ALPHA_W'(amax(ALPHA_W));
  localparam logic [PW:0]        RND  = (PW+1)'(rnd(ALPHA_W));

  logic [PW-1:0]   p1;
  logic [PW-1:0]   p2;
  logic [PW:0]     sum;
  logic [CH_W-1:0] mix;
  logic [CH_W-1:0] res;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
    end else if (s1_load) begin
      p1 <= PW'(in1) * PW'(alpha);
      p2 <= PW'(in2) * PW'(AMAX - alpha);
    end
  end

  // Top bit of sum is always zero: max sum stays below 2**PW.
  assign sum = {1'b0, p1} + {1'b0, p2} + RND;
  assign mix = CH_W'(sum >> ALPHA_W);

  if (EXACT_ENDS != 0) begin : g_exact
    logic [CH_W-1:0] c1;
    logic [CH_W-1:0] c2;

    always_ff @(posedge clk) begin
      if (rst) begin
        c1 <= '0;
        c2 <= '0;
      end else if (s1_load) begin
        c1 <= in1;
        c2 <= in2;
      end
    end

    always_comb begin
      res = mix;
      unique case (1'b1)
        a_max:   res = c1;
        a_zero:  res = c2;
        default: res = mix;
      endcase
    end
  end else begin : g_formula
    logic unused_ends;
    assign unused_ends = a_zero ^ a_max;
    assign res = mix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outp <= '0;
    end else if (s2_load) begin
      outp <= res;
    end
  end

endmodule

// File: rtl/pipelined_alpha_blender.sv
// Multi-channel two-stage alpha blender with valid/ready flow control.
// Holds pipeline control and alpha end detection; lanes hold the data.
module pipelined_alpha_blender
  import blend_pkg::*;
#(
  parameter int CH_W       = 12,
  parameter int N_CH       = 3,
  parameter int ALPHA_W    = 8,
  parameter int EXACT_ENDS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*CH_W-1:0]   in1,
  input  logic [N_CH*CH_W-1:0]   in2,
  input  logic [ALPHA_W-1:0]     alpha,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CH*CH_W-1:0]   outp
);

  localparam logic [ALPHA_W-1:0] AMAX = ALPHA_W'(amax(ALPHA_W));

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic s1_zero;
  logic s1_max;
  logic s1_load;
  logic s2_load;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Data registers only load real beats; bubbles just clear valid.
  assign s1_load = s1_adv & in_valid;
  assign s2_load = s2_adv & s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_max   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        s1_zero  <= (alpha == '0);
        s1_max   <= (alpha == AMAX);
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    blend_lane #(
      .CH_W      (CH_W),
      .ALPHA_W   (ALPHA_W),
      .EXACT_ENDS(EXACT_ENDS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .s1_load(s1_load),
      .s2_load(s2_load),
      .in1    (in1[c*CH_W +: CH_W]),
      .in2    (in2[c*CH_W +: CH_W]),
      .alpha  (alpha),
      .a_zero (s1_zero),
      .a_max  (s1_max),
      .outp   (outp[c*CH_W +: CH_W])
    );
  end

endmodule

// File: tb/tb_pipelined_alpha_blender.sv
// Self-checking bench for pipelined_alpha_blender.
// Scenario tasks with a queue scoreboard and an arithmetic reference model.
module tb_pipelined_alpha_blender;

  localparam int CW  = 12;
  localparam int NC  = 3;
  localparam int AW  = 8;
  localparam int DW  = CW * NC;
  localparam int WCW = 10;
  localparam int WNC = 4;
  localparam int WAW = 6;
  localparam int WDW = WCW * WNC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in1       = '0;
  logic [DW-1:0] in2       = '0;
  logic [AW-1:0] alpha     = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] outp;
  logic          ne_in_ready;
  logic          ne_out_valid;
  logic [DW-1:0] ne_outp;

  logic           w_in_valid  = 1'b0;
  logic           w_out_ready = 1'b0;
  logic [WDW-1:0] w_in1       = '0;
  logic [WDW-1:0] w_in2       = '0;
  logic [WAW-1:0] w_alpha     = '0;
  logic           w_in_ready;
  logic           w_out_valid;
  logic [WDW-1:0] w_outp;

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];

  pipelined_alpha_blender dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alpha(alpha),
    .out_valid(out_valid), .out_ready(out_ready),
    .outp(outp)
  );

  pipelined_alpha_blender #(.EXACT_ENDS(0)) dut_ne (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ne_in_ready),
    .in1(in1), .in2(in2), .alpha(alpha),
    .out_valid(ne_out_valid), .out_ready(out_ready),
    .outp(ne_outp)
  );

  pipelined_alpha_blender #(
    .CH_W(WCW), .N_CH(WNC), .ALPHA_W(WAW), .EXACT_ENDS(1)
  ) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in1(w_in1), .in2(w_in2), .alpha(w_alpha),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .outp(w_outp)
  );

  function automatic logic [63:0] model(
    input logic [63:0] a, input logic [63:0] b, input logic [63:0] al,
    input int chw, input int nch, input int aw, input bit exact);
    logic [63:0] amx, rn, mask, x, y, v, r;
    amx  = (64'd1 << aw) - 64'd1;
    rn   = (64'd1 << (aw - 1)) - 64'd1;
    mask = (64'd1 << chw) - 64'd1;
    r    = '0;
    for (int c = 0; c < nch; c++) begin
      x = (a >> (c * chw)) & mask;
      y = (b >> (c * chw)) & mask;
      if (exact && al == amx) v = x;
      else if (exact && al == 0) v = y;
      else v = (x * al + y * (amx - al) + rn) >> aw;
      r = r | (v << (c * chw));
    end
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] pick_alpha(input int aw);
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 64'd0;
    if (s == 1) return (64'd1 << aw) - 64'd1;
    return 64'($urandom_range(0, (1 << aw) - 1));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    w_in_valid = 1'b0;
    w_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (outp !== '0) begin
      errors++;
      $display("FAIL reset_outp got %h want 0", outp);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wide got v=%b r=%b want v=0 r=1",
               w_out_valid, w_in_ready);
    end
  endtask

  task automatic test_mid_blend();
    logic [DW-1:0] exp_px;
    exp_px = {NC{12'h7FF}};
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in1 = {NC{12'hFFF}};
    in2 = '0;
    alpha = 8'h80;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept in_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_early out_valid got %b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || outp !== exp_px) begin
      errors++;
      $display("FAIL mid_blend got v=%b %h want v=1 %h",
               out_valid, outp, exp_px);
    end
  endtask

  task automatic test_ends();
    logic [DW-1:0] b1[2];
    logic [DW-1:0] b2[2];
    logic [DW-1:0] e1[2];
    logic [DW-1:0] e0[2];
    logic [AW-1:0] ba[2];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    b1[0] = {NC{12'hABC}}; b2[0] = '0;
    ba[0] = 8'hFF;
    e1[0] = {NC{12'hABC}}; e0[0] = {NC{12'hAB1}};
    b1[1] = {NC{12'h5A5}}; b2[1] = {NC{12'h123}};
    ba[1] = 8'h00;
    e1[1] = {NC{12'h123}}; e0[1] = {NC{12'h122}};
    @(posedge clk);
    #1 out_ready = 1'b1;
    while (got < 2 && cyc < 20) begin
      in_valid = (sent < 2);
      if (sent < 2) begin
        in1 = b1[sent];
        in2 = b2[sent];
        alpha = ba[sent];
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        checks++;
        if (outp !== e1[got]) begin
          errors++;
          $display("FAIL ends_exact[%0d] got %h want %h", got, outp, e1[got]);
        end
        checks++;
        if (ne_out_valid !== 1'b1 || ne_outp !== e0[got]) begin
          errors++;
          $display("FAIL ends_formula[%0d] got %h want %h",
                   got, ne_outp, e0[got]);
        end
        got++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid = 1'b0;
    if (got < 2) begin
      checks++;
      errors++;
      $display("FAIL ends_timeout got %0d beats want 2", got);
    end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] pa[4];
    logic [DW-1:0] pb[4];
    logic [AW-1:0] pal[4];
    logic [63:0] hold;
    logic [63:0] exp_v;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    pa[0] = 36'h123456789; pb[0] = 36'hFEDCBA987; pal[0] = 8'h10;
    pa[1] = 36'h0F00F00F0; pb[1] = 36'h111222333; pal[1] = 8'h40;
    pa[2] = 36'hFFF000FFF; pb[2] = 36'h000FFF000; pal[2] = 8'hC0;
    pa[3] = 36'hA5A5A5A5A; pb[3] = 36'h5A5A5A5A5; pal[3] = 8'hFF;
    hold = model(64'(pa[0]), 64'(pb[0]), 64'(pal[0]), CW, NC, AW, 1'b1);
    q.delete();
    @(posedge clk);
    #1;
    while (got < 4 && cyc < 40) begin
      out_ready = (cyc >= 7);
      in_valid = (sent < 4);
      if (sent < 4) begin
        in1 = pa[sent];
        in2 = pb[sent];
        alpha = pal[sent];
      end
      @(negedge clk);
      if (cyc >= 2 && cyc < 7) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready cyc %0d got %b want 0", cyc, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || outp !== hold[DW-1:0]) begin
          errors++;
          $display("FAIL bp_hold cyc %0d got v=%b %h want v=1 %h",
                   cyc, out_valid, outp, hold[DW-1:0]);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(64'(in1), 64'(in2), 64'(alpha), CW, NC, AW, 1'b1));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra got %h want no beat", outp);
        end else begin
          exp_v = q.pop_front();
          if (outp !== exp_v[DW-1:0]) begin
            errors++;
            $display("FAIL bp_order[%0d] got %h want %h",
                     got, outp, exp_v[DW-1:0]);
          end
        end
        got++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d left %0d want 4 and 0", got, q.size());
    end
  endtask

  task automatic test_throughput();
    logic [63:0] t;
    logic [63:0] exp_v;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    bit need = 1'b1;
    q.delete();
    @(posedge clk);
    #1 out_ready = 1'b1;
    while (got < 100 && cyc < 400) begin
      in_valid = (sent < 100);
      if (sent < 100 && need) begin
        t = rand64(); in1 = t[DW-1:0];
        t = rand64(); in2 = t[DW-1:0];
        t = pick_alpha(AW); alpha = t[AW-1:0];
        need = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(model(64'(in1), 64'(in2), 64'(alpha), CW, NC, AW, 1'b1));
        sent++;
        need = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        last = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL tp_extra got %h want no beat", outp);
        end else begin
          exp_v = q.pop_front();
          if (outp !== exp_v[DW-1:0]) begin
            errors++;
            $display("FAIL tp_data[%0d] got %h want %h",
                     got, outp, exp_v[DW-1:0]);
          end
        end
        got++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 100 || last - first != 99) begin
      errors++;
      $display("FAIL tp_rate got %0d beats over %0d cycles want 100 over 99",
               got, last - first);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in1 = {NC{12'h777}};
    in2 = {NC{12'h333}};
    alpha = 8'h55;
    @(posedge clk);
    #1 in1 = {NC{12'h999}};
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_full got v=%b r=%b want v=1 r=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || outp !== '0) begin
      errors++;
      $display("FAIL rm_flush got v=%b %h want v=0 0", out_valid, outp);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_in_ready got %b want 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rm_ghost cyc %0d got v=%b want 0", i, out_valid);
      end
    end
    q.delete();
  endtask

  task automatic test_random_wide();
    logic [63:0] t;
    logic [63:0] exp_v;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit acc = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    while (got < 1000 && cyc < 20000) begin
      if (acc || !w_in_valid) begin
        w_in_valid = 1'b0;
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          t = rand64(); w_in1 = t[WDW-1:0];
          t = rand64(); w_in2 = t[WDW-1:0];
          t = pick_alpha(WAW); w_alpha = t[WAW-1:0];
          w_in_valid = 1'b1;
        end
      end
      acc = 1'b0;
      w_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (w_in_valid && w_in_ready) begin
        q.push_back(model(64'(w_in1), 64'(w_in2), 64'(w_alpha),
                          WCW, WNC, WAW, 1'b1));
        sent++;
        acc = 1'b1;
      end
      if (w_out_valid && w_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rw_extra got %h want no beat", w_outp);
        end else begin
          exp_v = q.pop_front();
          if (w_outp !== exp_v[WDW-1:0]) begin
            errors++;
            $display("FAIL rw_data[%0d] got %h want %h",
                     got, w_outp, exp_v[WDW-1:0]);
          end
        end
        got++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    w_in_valid = 1'b0;
    checks++;
    if (got != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL rw_count got %0d left %0d want 1000 and 0",
               got, q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mid_blend();
    test_ends();
    test_back_pressure();
    test_throughput();
    test_reset_mid();
    test_random_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
